char_console_writer: RTL
========================

Name: char_console_writer

Overview:
- Upstream feeder of the 2048x8 character RAM: accepts an ASCII byte stream over a valid/ready handshake and keeps a text cursor.
- Translates printable characters and a small control-code set into single-cycle RAM write strobes.
- Runs an automatic whole-screen clear after reset and on request.
- Sits between the CPU/UART byte source and the character RAM write port; the cursor outputs feed the VGA cursor overlay.

Parameters:
- COLS, 80, characters per row; requires COLS*ROWS <= 2048.
- ROWS, 25, rows per screen.
- BLANK, 8'h20, fill character for clear and backspace.
- TAB_W, 8, tab stop spacing; must be a power of two.

Ports:
- CLK  in  1  system clock, all logic on posedge.
- RST_N  in  1  asynchronous active-low reset.
- in_data  in  8  ASCII byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  byte accepted on a cycle with in_valid && in_ready; combinational: (state==IDLE) && !clear_req.
- clear_req  in  1  one-cycle request to clear the screen and home the cursor.
- write_character_pos  out  11  RAM write address, registered.
- write_character  out  8  RAM write data, registered.
- write_strobe  out  1  RAM write enable, registered.
- cursor_pos  out  11  linear cursor address, row*COLS+col.
- cursor_row  out  $clog2(ROWS)  cursor row.
- cursor_col  out  $clog2(COLS)  cursor column.
- busy  out  1  high while state==CLEAR.

Behaviour:
- Reset (async, RST_N low):
  - write_strobe, write_character_pos, write_character = 0.
  - cursor_pos, cursor_row, cursor_col = 0.
  - state = CLEAR, clear counter = 0, so in_ready = 0 and busy = 1.
- States: CLEAR, IDLE.
- CLEAR:
  - Each cycle: write_strobe = 1, write_character_pos = counter, write_character = BLANK; counter increments.
  - After writing address COLS*ROWS-1, go to IDLE with cursor = 0.
  - Exactly COLS*ROWS strobes, addresses 0..COLS*ROWS-1 in order, no gaps.
  - clear_req is ignored while in CLEAR; the clear does not restart.
  - Reset asserted mid-clear restarts the clear from address 0.
- IDLE:
  - clear_req = 1 moves to CLEAR on the next edge, counter = 0; in_ready is 0 that cycle, so no byte is accepted.
  - On a byte accept, the write (if any) appears on the outputs the next cycle (latency 1). The cursor updates on the same edge.
  - Back-to-back accepts run every cycle; throughput is 1 byte/clk.
  - write_strobe is 0 on any cycle with no write.
- Per-byte actions:
  - 0x20..0x7E: write the byte at cursor_pos, then advance the cursor.
  - 0x0A (LF): col = 0, row+1; no write.
  - 0x0D (CR): col = 0; no write.
  - 0x08 (BS): if col > 0, col-1 and write BLANK at the new position. If col == 0, no change and no write.
  - 0x09 (TAB): col = next multiple of TAB_W strictly greater than col. If the result is >= COLS, col = 0 and row+1. No write.
  - 0x0C (FF): same as clear_req, i.e. go to CLEAR.
  - All other bytes: consumed, no action.
- Cursor rules:
  - Advance past col COLS-1: col = 0, row+1.
  - row+1 from ROWS-1 wraps to row 0. There is no scrolling and no existing content is cleared.
- Arithmetic:
  - cursor_pos is maintained incrementally alongside a row_base register (row*COLS); no multiplier.
  - LF: pos = row_base + COLS, or 0 on wrap.
  - CR: pos = row_base.
  - BS: pos - 1.
  - TAB: pos = row_base + new col.
  - pos never exceeds COLS*ROWS-1.

Decomposition:
- Shared package:
  - ASCII constants: ASCII_BS, ASCII_TAB, ASCII_LF, ASCII_FF, ASCII_CR, ASCII_SPACE, printable range bounds.
  - State enum: CLEAR/IDLE.
  - Screen geometry defaults.
- No sub-module required. Cursor/row_base update and the clear counter stay inline; the clear counter reuses the write address register.

Test Plan:
- Release reset -> exactly 2000 strobes, pos 0..1999, data 0x20, busy high throughout. Then in_ready = 1, cursor_pos = 0.
- After the clear, send "Hi" back-to-back (in_valid held 2 cycles) -> strobes (0,0x48) and (1,0x69) on consecutive cycles, each 1 cycle after accept; cursor_pos = 2.
- Cursor at col 79 row 0, send 'A' -> write at pos 79, cursor row 1 col 0 pos 80. Cursor at row 24 col 5, send LF -> cursor pos 0, no strobe.
- Cursor col 3 row 2 (pos 163):
  - BS -> write (162,0x20), col 2.
  - TAB -> col 8, pos 168, no strobe.
  - From col 0, BS -> no strobe, pos unchanged.
- In IDLE, assert clear_req and in_valid with 'Z' together -> 'Z' not accepted, 2000 BLANK strobes, then cursor 0. Pulse clear_req mid-clear -> still exactly 2000 strobes total.
- Assert RST_N low at clear address 1000 -> outputs zero immediately. On release, the clear restarts at address 0; then send 0x0C -> a second full clear.

Source files
------------

// File: rtl/char_console_writer_pkg.sv
// Shared constants and types for the character console writer: ASCII control
// codes, screen geometry defaults and the writer state encoding.
package char_console_writer_pkg;

    localparam int          DEF_COLS  = 80;
    localparam int          DEF_ROWS  = 25;
    localparam int          DEF_TAB_W = 8;
    localparam logic [7:0]  DEF_BLANK = 8'h20;

    // The character RAM is 2048 deep, so every address fits in 11 bits.
    localparam int          ADDR_W    = 11;

    localparam logic [7:0]  ASCII_BS    = 8'h08;
    localparam logic [7:0]  ASCII_TAB   = 8'h09;
    localparam logic [7:0]  ASCII_LF    = 8'h0A;
    localparam logic [7:0]  ASCII_FF    = 8'h0C;
    localparam logic [7:0]  ASCII_CR    = 8'h0D;
    localparam logic [7:0]  ASCII_SPACE = 8'h20;
    localparam logic [7:0]  PRINT_MIN   = 8'h20;
    localparam logic [7:0]  PRINT_MAX   = 8'h7E;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/char_console_writer.sv
// Turns an ASCII byte stream into character RAM write strobes, tracks the text
// cursor, and sweeps the whole screen with BLANK after reset or on request.
module char_console_writer
    import char_console_writer_pkg::*;
#(
    parameter int         COLS  = DEF_COLS,
    parameter int         ROWS  = DEF_ROWS,
    parameter logic [7:0] BLANK = DEF_BLANK,
    parameter int         TAB_W = DEF_TAB_W
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [7:0]                in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      clear_req,
    output logic [ADDR_W-1:0]         write_character_pos,
    output logic [7:0]                write_character,
    output logic                      write_strobe,
    output logic [ADDR_W-1:0]         cursor_pos,
    output logic [$clog2(ROWS)-1:0]   cursor_row,
    output logic [$clog2(COLS)-1:0]   cursor_col,
    output logic                      busy
);

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
    localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0]  ONE_C     = COL_W'(1);
    localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0]  ONE_R     = ROW_W'(1);
    localparam logic [COL_W:0]    TAB_MASK  = (COL_W + 1)'(TAB_W - 1);
    localparam logic [COL_W:0]    COLS_E    = (COL_W + 1)'(COLS);
    localparam logic [COL_W:0]    ONE_E     = (COL_W + 1)'(1);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   wr_pos_reg, wr_pos_next;
    logic [7:0]          wr_data_reg, wr_data_next;
    logic                wr_strobe_reg, wr_strobe_next;
    logic [ADDR_W-1:0]   pos_reg, pos_next;
    logic [ADDR_W-1:0]   row_base_reg, row_base_next;
    logic [ROW_W-1:0]    row_reg, row_next;
    logic [COL_W-1:0]    col_reg, col_next;

    logic                row_wrap;
    logic [ROW_W-1:0]    row_inc;
    logic [ADDR_W-1:0]   base_inc;
    logic [COL_W:0]      tab_col;

    // Next-line values shared by LF, TAB overflow and printable wrap.
    assign row_wrap = (row_reg == ROW_MAX);
    assign row_inc  = row_wrap ? '0 : row_reg + ONE_R;
    assign base_inc = row_wrap ? '0 : row_base_reg + COLS_A;
    assign tab_col  = ({1'b0, col_reg} | TAB_MASK) + ONE_E;

    assign in_ready            = (state_reg == IDLE) && !clear_req;
    assign busy                = (state_reg == CLEAR);
    assign write_character_pos = wr_pos_reg;
    assign write_character     = wr_data_reg;
    assign write_strobe        = wr_strobe_reg;
    assign cursor_pos          = pos_reg;
    assign cursor_row          = row_reg;
    assign cursor_col          = col_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg     <= CLEAR;
            wr_pos_reg    <= '0;
            wr_data_reg   <= '0;
            wr_strobe_reg <= 1'b0;
            pos_reg       <= '0;
            row_base_reg  <= '0;
            row_reg       <= '0;
            col_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            wr_pos_reg    <= wr_pos_next;
            wr_data_reg   <= wr_data_next;
            wr_strobe_reg <= wr_strobe_next;
            pos_reg       <= pos_next;
            row_base_reg  <= row_base_next;
            row_reg       <= row_next;
            col_reg       <= col_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wr_pos_next    = wr_pos_reg;
        wr_data_next   = wr_data_reg;
        wr_strobe_next = 1'b0;
        pos_next       = pos_reg;
        row_base_next  = row_base_reg;
        row_next       = row_reg;
        col_next       = col_reg;

        case (state_reg)
            CLEAR: begin
                // The write address doubles as the clear counter; a low strobe
                // marks the first sweep cycle, which must write address 0.
                if (wr_strobe_reg && (wr_pos_reg == LAST_ADDR)) begin
                    state_next    = IDLE;
                    pos_next      = '0;
                    row_base_next = '0;
                    row_next      = '0;
                    col_next      = '0;
                end else begin
                    wr_strobe_next = 1'b1;
                    wr_data_next   = BLANK;
                    wr_pos_next    = wr_strobe_reg ? wr_pos_reg + ONE_A : '0;
                end
            end
            IDLE: begin
                if (clear_req) begin
                    state_next  = CLEAR;
                    wr_pos_next = '0;
                end else if (in_valid) begin
                    case (in_data)
                        ASCII_LF: begin
                            col_next      = '0;
                            row_next      = row_inc;
                            row_base_next = base_inc;
                            pos_next      = base_inc;
                        end
                        ASCII_CR: begin
                            col_next = '0;
                            pos_next = row_base_reg;
                        end
                        ASCII_BS: begin
                            if (col_reg != '0) begin
                                col_next       = col_reg - ONE_C;
                                pos_next       = pos_reg - ONE_A;
                                wr_strobe_next = 1'b1;
                                wr_pos_next    = pos_reg - ONE_A;
                                wr_data_next   = BLANK;
                            end
                        end
                        ASCII_TAB: begin
                            if (tab_col >= COLS_E) begin
                                col_next      = '0;
                                row_next      = row_inc;
                                row_base_next = base_inc;
                                pos_next      = base_inc;
                            end else begin
                                col_next = tab_col[COL_W-1:0];
                                pos_next = row_base_reg + ADDR_W'(tab_col);
                            end
                        end
                        ASCII_FF: begin
                            state_next  = CLEAR;
                            wr_pos_next = '0;
                        end
                        default: begin
                            if ((in_data >= PRINT_MIN) && (in_data <= PRINT_MAX)) begin
                                wr_strobe_next = 1'b1;
                                wr_pos_next    = pos_reg;
                                wr_data_next   = in_data;
                                if (col_reg == COL_MAX) begin
                                    col_next      = '0;
                                    row_next      = row_inc;
                                    row_base_next = base_inc;
                                    pos_next      = base_inc;
                                end else begin
                                    col_next = col_reg + ONE_C;
                                    pos_next = pos_reg + ONE_A;
                                end
                            end
                        end
                    endcase
                end
            end
        endcase
    end

endmodule
